dst_serializer: RTL

- Output-side counterpart of the serial-in source loader that feeds the compressor.
- Captures the compressor's parallel result bits (dst0..dstN-1, packed into one bus) on a start request.
- Streams the captured bits out on a single serial line, LSB (dst0) first, under a valid/ready handshake.
- Lets a bench or off-chip monitor read a full compressor result through one pin, mirroring how the operands are shifted in.

---
 rtl/dst_serializer.sv | 98 +++++++++
 1 files changed

// File: rtl/dst_serializer.sv
// Captures the compressor's parallel result bus on start and streams it LSB-first over a valid/ready serial line.
// Define DST_SERIALIZER_PARITY_EN to append an even-parity bit as the final frame bit.
`timescale 1ns/1ps
module dst_serializer #(
  parameter int NDST  = 36,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NDST-1:0] dst,
  input  logic            start,
  input  logic            sout_ready,
  output logic            sout,
  output logic            sout_valid,
  output logic            sout_last,
  output logic            busy,
  output logic            done
);

`ifdef DST_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = NDST + 1;
`else
  localparam int FRAME_LEN = NDST;
`endif

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [FRAME_LEN-1:0]   capture;
  logic                   accept;

  // Parity is folded in at capture so the shifter never needs to know about it.
`ifdef DST_SERIALIZER_PARITY_EN
  assign capture = {^dst, dst};
`else
  assign capture = dst;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign accept = (state_q == SHIFT) && sout_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = capture;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial outputs are gated by state so the line reads 0 whenever no frame is in flight.
  assign sout_valid = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign sout       = (state_q == SHIFT) & shreg_q[0];
  assign sout_last  = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign done       = done_q;

endmodule
